// File: rtl/sha256_unpad_if.sv
// Handshake bundle between a padded-block source and the SHA-256 unpadding receiver.
// The slave modport is the receiver's view; the master modport is the driving side.
interface sha256_unpad_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic        err;
    logic [8:0]  msg_len;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_bits, out_valid, out_last, done, err, msg_len
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_bits, out_valid, out_last, done, err, msg_len
    );
endinterface

// File: rtl/sha256_unpad_rx.sv
// Collects one padded SHA-256 block, validates its padding, recovers the message
// length and streams the original message back out as 32-bit words.
//
// state   | meaning
// COLLECT | accepting the 16 block words into the buffer
// CHECK   | one cycle: decode length, verify marker and fill
// EMIT    | streaming ceil(L/32) message words, last word masked
// DONE    | one-cycle done pulse with err / msg_len
module sha256_unpad_rx #(
    parameter int CHECK_FILL = 1,
    parameter int MAX_LEN    = 447
) (
    input  logic          clk,
    input  logic          rst,
    sha256_unpad_if.slave bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  buffer [16];
    logic [3:0]   cnt;
    logic [3:0]   emit_k;
    logic [8:0]   len_q;
    logic         err_q;

    logic [511:0] block;
    logic [63:0]  len_full;
    logic [8:0]   len9;
    logic         len_bad;
    logic         marker_bad;
    logic         fill_bad;
    logic         chk_err;
    logic [8:0]   len_m1;
    logic [3:0]   last_idx;
    logic [5:0]   last_bits;

    always_comb begin
        block = '0;
        for (int w = 0; w < 16; w++) begin
            block[511 - 32*w -: 32] = buffer[w];
        end
    end

    assign len_full   = block[63:0];
    assign len9       = len_full[8:0];
    assign len_bad    = len_full > 64'(MAX_LEN);
    assign marker_bad = ~block[9'd511 - len9];

    // Fill region runs from just below the marker down to the length field.
    always_comb begin
        fill_bad = 1'b0;
        for (int i = 64; i < 511; i++) begin
            if (((i + int'(len9)) <= 510) && block[i]) begin
                fill_bad = 1'b1;
            end
        end
    end

    assign chk_err = len_bad | marker_bad | ((CHECK_FILL != 0) & fill_bad);

    // (L-1)/32 is the index of the last word; (L-1)%32+1 its valid-bit count.
    assign len_m1    = len_q - 9'd1;
    assign last_idx  = len_m1[8:5];
    assign last_bits = {1'b0, len_m1[4:0]} + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (bus.in_valid && (cnt == 4'd15)) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (chk_err || (len9 == 9'd0)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready && (emit_k == last_idx)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = COLLECT;
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < 16; w++) begin
                buffer[w] <= '0;
            end
            cnt    <= '0;
            emit_k <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        buffer[cnt] <= bus.in_data;
                        cnt         <= cnt + 4'd1;
                    end
                end
                CHECK: begin
                    len_q  <= chk_err ? 9'd0 : len9;
                    err_q  <= chk_err;
                    emit_k <= '0;
                end
                EMIT: begin
                    if (bus.out_ready && (emit_k != last_idx)) begin
                        emit_k <= emit_k + 4'd1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_bits  = '0;
        bus.out_last  = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.msg_len   = '0;
        case (state)
            COLLECT: begin
                bus.in_ready = 1'b1;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (emit_k == last_idx) begin
                    bus.out_last = 1'b1;
                    bus.out_bits = last_bits;
                    bus.out_data = buffer[emit_k] & ~(32'hFFFF_FFFF >> last_bits);
                end else begin
                    bus.out_bits = 6'd32;
                    bus.out_data = buffer[emit_k];
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.err     = err_q;
                bus.msg_len = len_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_unpad_rx.sv
// Bench for sha256_unpad_rx: directed padding cases plus randomized blocks,
// scored against a whole-block model of the padding rules.
module tb_sha256_unpad_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_unpad_if bus ();

    sha256_unpad_rx #(.CHECK_FILL(1), .MAX_LEN(447)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  bits;
        logic        last;
    } out_t;

    typedef struct packed {
        logic       err;
        logic [8:0] len;
        logic [4:0] nw;
    } done_t;

    out_t  exp_out[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int out_mode = 0;
    int first_cyc = 0;
    int first_ov_cyc = -1;
    out_t first_ov;
    out_t last_xfer;
    int out_xfers = 0;
    int xfers_since_done = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic last_done_err;
    logic [8:0] last_done_len;
    int ir_low = 0;
    int target = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decode the block as a whole vector, then slice the masked message.
    task automatic model(input logic [511:0] blk);
        logic [63:0]  lf;
        logic [511:0] ones;
        logic [511:0] msg;
        int           len;
        int           n;
        logic         e;
        out_t         o;
        done_t        d;
        ones = '1;
        lf   = blk[63:0];
        e    = 1'b0;
        len  = 0;
        if (lf > 64'd447) begin
            e = 1'b1;
        end else begin
            len = int'(lf);
            if (!blk[511 - len]) e = 1'b1;
            for (int i = 64; i <= 510 - len; i++) begin
                if (blk[i]) e = 1'b1;
            end
        end
        if (e) begin
            d.err = 1'b1;
            d.len = 9'd0;
            d.nw  = 5'd0;
        end else begin
            n   = (len + 31) / 32;
            msg = blk & ~(ones >> len);
            for (int k = 0; k < n; k++) begin
                o.data = msg[511 - 32*k -: 32];
                o.last = (k == n - 1);
                o.bits = o.last ? 6'(len - 32*k) : 6'd32;
                exp_out.push_back(o);
            end
            d.err = 1'b0;
            d.len = 9'(len);
            d.nw  = 5'(n);
        end
        exp_done.push_back(d);
    endtask

    function automatic logic [511:0] rnd_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [511:0] make_block(input int len);
        logic [511:0] b;
        logic [511:0] ones;
        ones = '1;
        b = rnd_block() & ~(ones >> len);
        b[511 - len] = 1'b1;
        b[63:0] = 64'(len);
        return b;
    endfunction

    task automatic send_block(input logic [511:0] blk, input int gap_pct, input bit hold);
        model(blk);
        for (int k = 0; k < 16; k++) begin
            bit sent;
            int guard;
            sent  = 1'b0;
            guard = 0;
            while (!sent) begin
                @(negedge clk);
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    bus.in_valid = 1'b0;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = blk[511 - 32*k -: 32];
                    if (bus.in_ready) begin
                        sent = 1'b1;
                        if (k == 0) first_cyc = cyc;
                    end
                end
                guard++;
                if (!sent && guard > 300) begin
                    chk("in_accept_timeout", 64'd0, 64'd1);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_dones(input int tgt);
        int guard;
        guard = 0;
        while (done_cnt < tgt && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt < tgt) chk("done_timeout", 64'(done_cnt), 64'(tgt));
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_marks();
        first_ov_cyc = -1;
        done_cyc     = -1;
        ir_low       = 0;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        exp_out.delete();
        exp_done.delete();
        xfers_since_done = 0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Output scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!bus.in_ready) ir_low++;
            if (bus.out_valid) begin
                if (first_ov_cyc < 0) begin
                    first_ov_cyc = cyc;
                    first_ov = '{data: bus.out_data, bits: bus.out_bits, last: bus.out_last};
                end
                if (exp_out.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    chk("out_data", 64'(bus.out_data), 64'(exp_out[0].data));
                    chk("out_bits", 64'(bus.out_bits), 64'(exp_out[0].bits));
                    chk("out_last", 64'(bus.out_last), 64'(exp_out[0].last));
                    if (bus.out_ready) begin
                        last_xfer = '{data: bus.out_data, bits: bus.out_bits, last: bus.out_last};
                        out_xfers++;
                        xfers_since_done++;
                        void'(exp_out.pop_front());
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc      = cyc;
                last_done_err = bus.err;
                last_done_len = bus.msg_len;
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    chk("done_err", 64'(bus.err), 64'(exp_done[0].err));
                    chk("done_msg_len", 64'(bus.msg_len), 64'(exp_done[0].len));
                    chk("words_per_block", 64'(xfers_since_done), 64'(exp_done[0].nw));
                    void'(exp_done.pop_front());
                end
                xfers_since_done = 0;
            end else begin
                chk("err_idle", 64'(bus.err), 64'd0);
                chk("msg_len_idle", 64'(bus.msg_len), 64'd0);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (out_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ~bus.out_ready;
            2: bus.out_ready = 1'($urandom_range(1));
            default: begin end
        endcase
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, summary not printed normally");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b;
        int base;
        int kind;
        int len;
        int gap;
        bit hold;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_bits", 64'(bus.out_bits), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_err", 64'(bus.err), 64'd0);
        chk("reset_msg_len", 64'(bus.msg_len), 64'd0);
        #2 rst = 1'b0;

        // "abc"
        clear_marks();
        send_block({32'h61626380, {14{32'h0}}, 32'h18}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("abc_out_cycle", 64'(first_ov_cyc), 64'(first_cyc + 17));
        chk("abc_out_data", 64'(first_ov.data), 64'h61626300);
        chk("abc_out_bits", 64'(first_ov.bits), 64'd24);
        chk("abc_out_last", 64'(first_ov.last), 64'd1);
        chk("abc_done_cycle", 64'(done_cyc), 64'(first_cyc + 18));
        chk("abc_err", 64'(last_done_err), 64'd0);
        chk("abc_msg_len", 64'(last_done_len), 64'd24);
        chk("abc_in_ready_low", 64'(ir_low), 64'd3);

        // L = 0
        clear_marks();
        send_block({32'h80000000, {15{32'h0}}}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("l0_no_out", 64'(first_ov_cyc), 64'(-1));
        chk("l0_done_cycle", 64'(done_cyc), 64'(first_cyc + 17));
        chk("l0_err", 64'(last_done_err), 64'd0);
        chk("l0_msg_len", 64'(last_done_len), 64'd0);
        chk("l0_in_ready_low", 64'(ir_low), 64'd2);

        // L = 64 under toggling backpressure
        out_mode = 1;
        base = out_xfers;
        send_block({32'h01234567, 32'h89ABCDEF, 32'h80000000, {12{32'h0}}, 32'h40}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("l64_words", 64'(out_xfers - base), 64'd2);
        chk("l64_last_data", 64'(last_xfer.data), 64'h89ABCDEF);
        chk("l64_last_bits", 64'(last_xfer.bits), 64'd32);
        chk("l64_last_flag", 64'(last_xfer.last), 64'd1);
        out_mode = 0;

        // padding errors
        clear_marks();
        send_block({32'h61626380, {14{32'h0}}, 32'h1C0}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("l448_err", 64'(last_done_err), 64'd1);
        chk("l448_no_out", 64'(first_ov_cyc), 64'(-1));
        clear_marks();
        send_block({32'h61626300, {14{32'h0}}, 32'h18}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("nomarker_err", 64'(last_done_err), 64'd1);
        chk("nomarker_len", 64'(last_done_len), 64'd0);
        send_block({32'h61626380, {4{32'h0}}, 32'h1, {9{32'h0}}, 32'h18}, 0, 1'b0);
        target++;
        wait_dones(target);
        chk("fill_err", 64'(last_done_err), 64'd1);

        // reset during EMIT after one of three words
        out_mode = 3;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        base = out_xfers;
        send_block(make_block(80), 0, 1'b0);
        begin
            int guard;
            guard = 0;
            while (!bus.out_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            chk("rst_test_out_valid_seen", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        reset_mid();
        chk("rst_test_words_before", 64'(out_xfers - base), 64'd1);
        out_mode = 0;
        target = done_cnt + 1;
        clear_marks();
        send_block({32'h61626380, {14{32'h0}}, 32'h18}, 0, 1'b0);
        wait_dones(target);
        chk("post_rst_msg_len", 64'(last_done_len), 64'd24);
        chk("post_rst_out_data", 64'(first_ov.data), 64'h61626300);

        // back-to-back blocks with in_valid held high
        clear_marks();
        send_block(make_block(100), 0, 1'b1);
        send_block(make_block(37), 0, 1'b0);
        target += 2;
        wait_dones(target);
        chk("b2b_in_ready_low", 64'(ir_low), 64'd10);
        chk("b2b_last_len", 64'(last_done_len), 64'd37);

        // randomized blocks
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(9));
            case (kind)
                6: begin
                    case ($urandom_range(6))
                        0: len = 0;
                        1: len = 1;
                        2: len = 31;
                        3: len = 32;
                        4: len = 33;
                        5: len = 446;
                        default: len = 447;
                    endcase
                    b = make_block(len);
                end
                7: begin
                    len = int'($urandom_range(447));
                    b = make_block(len);
                    b[511 - len] = 1'b0;
                end
                8: begin
                    len = int'($urandom_range(446));
                    b = make_block(len);
                    b[$urandom_range(510 - len, 64)] = 1'b1;
                end
                9: begin
                    b = make_block(int'($urandom_range(447)));
                    if ($urandom_range(1) == 1) b[63:0] = 64'(448 + $urandom_range(63));
                    else b[63:32] = $urandom | 32'h1;
                end
                default: begin
                    b = make_block(int'($urandom_range(447)));
                end
            endcase
            out_mode = int'($urandom_range(2));
            gap  = ($urandom_range(1) == 1) ? 20 : 0;
            hold = (it != 39) && ($urandom_range(3) == 0);
            send_block(b, gap, hold);
            target++;
            if (!hold) wait_dones(target);
        end

        chk("exp_out_left", 64'(exp_out.size()), 64'd0);
        chk("exp_done_left", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
